smc_ps2_hub: RTL and testbench
==============================

// Module: smc_ps2_hub
// PURPOSE
//  Multi-channel System Management Controller core. Register and transaction engine
//  between the I2C slave device interface and NCH PS/2 ports (ch0 = keyboard, ch1 = mouse, ...).
//  Holds one scan-code FIFO per channel. Forwards host PS/2 commands and reports per-channel
//  command status and overflow. The I2C slave, the ps2_port instances and the 1us pulser
//  stay outside this block.
// PARAMETERS
//  NCH      2  number of PS/2 channels, 1..4
//  FIFO_AW  3  per-channel FIFO depth = 2**FIFO_AW entries
// PORTS
//  clk6x        in   1      system clock, 48MHz
//  reset        in   1      synchronous reset, active-high
//  devsel_i     in   1      I2C slave selected for our address
//  rw_bit_i     in   1      1=I2C read, 0=write; valid while devsel_i=1
//  rxbyte_i     in   8      byte received from master
//  rxbyte_v_i   in   1      rxbyte_i valid, 1T
//  txbyte_o     out  8      next byte to transmit to master
//  txbyte_deq_i in   1      txbyte_o consumed, 1T
//  ps2_code_i   in   8*NCH  received scan code, ch c at [8c+7:8c]
//  ps2_code_v_i in   NCH    scan code valid, 1T per channel
//  ps2_busy_i   in   NCH    ps2_port busy; no command accepted while 1
//  ps2_acked_i  in   NCH    device ACKed our command, 1T
//  ps2_errd_i   in   NCH    command NACK/error, 1T
//  ps2_cmd_o    out  8*NCH  command byte per channel
//  ps2_cmd_v_o  out  NCH    command strobe, 1T, only when ps2_busy_i[c]=0
// BEHAVIOUR
//  Reset: txbyte_o=FF, ps2_cmd_o=0, ps2_cmd_v_o=0, regnum=00, byteidx=0, all FIFOs empty,
//   status[c]=00, ovf=0, no pending command. Reset mid-transfer aborts everything; queued
//   codes and pending commands are dropped.
//  Register map:
//   BUF[0]=07; BUF[c]=20+c (c>=1)         read: pop one code, 00 when empty
//   STAT[c]=18+2c                         read: 00 idle, 01 pending/in-flight, FA ACKed, FE error
//   CMD[c]=19+2c                          write: byte 2 = PS/2 command
//   OVF=30                                read: bit c = FIFO c dropped a code; clear-on-read
//   Unmapped registers read FF; writes to them are ignored.
//  byteidx: 2-bit, saturates at 3; cleared while devsel_i=0. Increments on rxbyte_v_i or txbyte_deq_i.
//   byteidx==0 and rxbyte_v_i: regnum<=rxbyte_i.
//   byteidx==1 and rxbyte_v_i, regnum=CMD[c]: pend[c]<=1, cmdbyte[c]<=rxbyte_i, status[c]<=01.
//   A write with pend[c] already 1 overwrites cmdbyte[c].
//  Command issue: pend[c] & !ps2_busy_i[c] -> ps2_cmd_v_o[c]=1 for 1T on the next clock; pend[c] cleared.
//   ps2_acked_i[c] -> status[c]=FA. ps2_errd_i[c] -> status[c]=FE. Both in the same cycle -> FE.
//   Reading STAT does not clear it.
//  Read path: while devsel_i & rw_bit_i, txbyte_o reloads every clk from regnum (1T latency).
//   For BUF[c], txvalid<=!empty[c] is loaded together with txbyte_o.
//   On txbyte_deq_i with regnum=BUF[c] & txvalid: pop FIFO c. A genuine 00 scan code is
//   popped too; empty is never popped.
//   On txbyte_deq_i with regnum=OVF: clear the ovf bits just transmitted. A bit set in the
//   same cycle stays set.
//  FIFO c: enqueue on ps2_code_v_i[c]. When full and no pop this cycle: code dropped, ovf[c]<=1.
//   Full with a pop in the same cycle: enqueue accepted, count unchanged.
//   Pointers are FIFO_AW+1 bits with wrap bit; full = same index, different wrap bit.
//  devsel_i falling mid-transfer leaves regnum held. A read without a preceding write reuses
//   the last regnum.
// CONFIGURATION
//  SMC_FLUSH_EN defined: register 31 is write-only. Byte 2 bit c=1 empties FIFO c and clears
//   ovf[c] on the next clk. A code arriving in that cycle is dropped. Reading 31 gives FF.
//  SMC_FLUSH_EN undefined: register 31 is unmapped (reads FF, writes ignored), no flush logic.
// TESTING
//  ps2_code ch0 = 1C,F0,1C; I2C read reg 07 x4 -> 1C,F0,1C,00; FIFO empty; no extra pop.
//  ch0 code 00 then I2C read 07 x2 -> 00 (popped, count 1->0), then 00 (no pop; no underflow).
//  9 codes into ch1 (FIFO_AW=3) with no reads -> read 30 = 02, read 30 again = 00; 21 returns
//   first 8 codes only.
//  Write 19,FF with ps2_busy_i[0]=1 for 50 clk -> STAT 18 reads 01; cmd_v pulses 1T (FF) one
//   clk after busy drops; ack -> 18 reads FA; 1B write + errd -> 1A reads FE.
//  FIFO full, code valid in the same clk as pop -> count stays 8, ovf stays 0.
//  Assert reset mid I2C read and with a pending command -> txbyte_o=FF, no cmd_v pulse, reads
//   return 00 and 18 reads 00.

Source files
------------

// File: rtl/smc_ps2_hub.sv
// smc_ps2_hub: I2C register/transaction engine for NCH PS/2 channels with per-channel scan-code FIFOs.
// Build macro SMC_FLUSH_EN adds the write-only FIFO flush register 0x31.
module smc_ps2_hub #(
   parameter int NCH     = 2,
   parameter int FIFO_AW = 3
) (
   input  logic             clk6x,
   input  logic             reset,
   input  logic             devsel_i,
   input  logic             rw_bit_i,
   input  logic [7:0]       rxbyte_i,
   input  logic             rxbyte_v_i,
   output logic [7:0]       txbyte_o,
   input  logic             txbyte_deq_i,
   input  logic [8*NCH-1:0] ps2_code_i,
   input  logic [NCH-1:0]   ps2_code_v_i,
   input  logic [NCH-1:0]   ps2_busy_i,
   input  logic [NCH-1:0]   ps2_acked_i,
   input  logic [NCH-1:0]   ps2_errd_i,
   output logic [8*NCH-1:0] ps2_cmd_o,
   output logic [NCH-1:0]   ps2_cmd_v_o
);
   localparam int               DEPTH   = 1 << FIFO_AW;
   localparam logic [7:0]       OVF_REG = 8'h30;
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   function automatic logic [7:0] buf_addr(input int c);
      return (c == 0) ? 8'h07 : 8'(32'h20 + c);
   endfunction

   function automatic logic [7:0] stat_addr(input int c);
      return 8'(32'h18 + c * 32'sd2);
   endfunction

   function automatic logic [7:0] cmd_addr(input int c);
      return 8'(32'h19 + c * 32'sd2);
   endfunction

   logic [7:0]       regnum_q, regnum_d;
   logic [1:0]       byteidx_q, byteidx_d;
   logic [7:0]       txbyte_q, txbyte_d;
   logic             txvalid_q, txvalid_d;
   logic [NCH-1:0]   pend_q, pend_d;
   logic [7:0]       cmdbyte_q [NCH];
   logic [7:0]       cmdbyte_d [NCH];
   logic [7:0]       status_q [NCH];
   logic [7:0]       status_d [NCH];
   logic [NCH-1:0]   ovf_q, ovf_d;
   logic [8*NCH-1:0] cmd_q, cmd_d;
   logic [NCH-1:0]   cmd_v_q, cmd_v_d;
   logic [FIFO_AW:0] wr_ptr_q [NCH];
   logic [FIFO_AW:0] wr_ptr_d [NCH];
   logic [FIFO_AW:0] rd_ptr_q [NCH];
   logic [FIFO_AW:0] rd_ptr_d [NCH];
   logic [7:0]       mem_q [NCH][DEPTH];

   logic [NCH-1:0]   empty_s, full_s, push_s, pop_s, drop_s, flush_s, clr_s;
   logic             ovf_rd_s, cmd_wr_s;
   logic [7:0]       rd_data_s;
   logic             rd_valid_s;

`ifdef SMC_FLUSH_EN
   localparam logic [7:0] FLUSH_REG = 8'h31;
   assign flush_s = (devsel_i && rxbyte_v_i && byteidx_q == 2'd1 && regnum_q == FLUSH_REG)
                    ? rxbyte_i[NCH-1:0] : {NCH{1'b0}};
`else
   assign flush_s = {NCH{1'b0}};
`endif

   // FIFO flags and push/pop/drop decisions; a pop frees the slot a same-cycle push needs
   always_comb begin
      ovf_rd_s = devsel_i & txbyte_deq_i & (regnum_q == OVF_REG);
      cmd_wr_s = devsel_i & rxbyte_v_i & (byteidx_q == 2'd1);
      clr_s    = ovf_rd_s ? txbyte_q[NCH-1:0] : {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
         full_s[c]  = (wr_ptr_q[c][FIFO_AW-1:0] == rd_ptr_q[c][FIFO_AW-1:0]) &&
                      (wr_ptr_q[c][FIFO_AW] != rd_ptr_q[c][FIFO_AW]);
         pop_s[c]   = devsel_i & txbyte_deq_i & txvalid_q &
                      (regnum_q == buf_addr(c)) & ~empty_s[c];
         push_s[c]  = ps2_code_v_i[c] & (~full_s[c] | pop_s[c]) & ~flush_s[c];
         drop_s[c]  = ps2_code_v_i[c] & full_s[c] & ~pop_s[c] & ~flush_s[c];
      end
   end

   // Register read multiplexer; unmapped addresses read FF
   always_comb begin
      rd_data_s  = 8'hFF;
      rd_valid_s = 1'b0;
      if (regnum_q == OVF_REG) begin
         rd_data_s = 8'(ovf_q);
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (regnum_q == buf_addr(c)) begin
               rd_data_s  = empty_s[c] ? 8'h00 : mem_q[c][rd_ptr_q[c][FIFO_AW-1:0]];
               rd_valid_s = ~empty_s[c];
            end else if (regnum_q == stat_addr(c)) begin
               rd_data_s = status_q[c];
            end else begin
               rd_data_s = rd_data_s;
            end
         end
      end
   end

   // Next-state logic for transfer tracking, command path and FIFO pointers
   always_comb begin
      regnum_d  = regnum_q;
      byteidx_d = byteidx_q;
      pend_d    = pend_q;
      cmd_d     = cmd_q;
      cmd_v_d   = {NCH{1'b0}};
      ovf_d     = (ovf_q & ~clr_s & ~flush_s) | drop_s;

      if (!devsel_i) begin
         byteidx_d = 2'd0;
      end else if ((rxbyte_v_i || txbyte_deq_i) && byteidx_q != 2'd3) begin
         byteidx_d = byteidx_q + 2'd1;
      end else begin
         byteidx_d = byteidx_q;
      end

      if (devsel_i && rxbyte_v_i && byteidx_q == 2'd0) begin
         regnum_d = rxbyte_i;
      end else begin
         regnum_d = regnum_q;
      end

      if (devsel_i && rw_bit_i) begin
         txbyte_d  = rd_data_s;
         txvalid_d = rd_valid_s;
      end else begin
         txbyte_d  = txbyte_q;
         txvalid_d = 1'b0;
      end

      for (int c = 0; c < NCH; c++) begin
         cmdbyte_d[c] = cmdbyte_q[c];

         if (pend_q[c] && !ps2_busy_i[c]) begin
            cmd_v_d[c]       = 1'b1;
            cmd_d[8*c +: 8]  = cmdbyte_q[c];
            pend_d[c]        = 1'b0;
         end else begin
            cmd_v_d[c] = 1'b0;
         end

         // error outranks ack; a fresh command write outranks both
         if (ps2_errd_i[c]) begin
            status_d[c] = 8'hFE;
         end else if (ps2_acked_i[c]) begin
            status_d[c] = 8'hFA;
         end else begin
            status_d[c] = status_q[c];
         end

         if (cmd_wr_s && regnum_q == cmd_addr(c)) begin
            pend_d[c]    = 1'b1;
            cmdbyte_d[c] = rxbyte_i;
            status_d[c]  = 8'h01;
         end else begin
            cmdbyte_d[c] = cmdbyte_q[c];
         end

         if (flush_s[c]) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = wr_ptr_q[c];
         end else begin
            wr_ptr_d[c] = push_s[c] ? wr_ptr_q[c] + PTR_ONE : wr_ptr_q[c];
            rd_ptr_d[c] = pop_s[c]  ? rd_ptr_q[c] + PTR_ONE : rd_ptr_q[c];
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk6x) begin
      if (reset) begin
         regnum_q  <= 8'h00;
         byteidx_q <= 2'd0;
         txbyte_q  <= 8'hFF;
         txvalid_q <= 1'b0;
         pend_q    <= {NCH{1'b0}};
         ovf_q     <= {NCH{1'b0}};
         cmd_q     <= {(8*NCH){1'b0}};
         cmd_v_q   <= {NCH{1'b0}};
         for (int c = 0; c < NCH; c++) begin
            cmdbyte_q[c] <= 8'h00;
            status_q[c]  <= 8'h00;
            wr_ptr_q[c]  <= {(FIFO_AW+1){1'b0}};
            rd_ptr_q[c]  <= {(FIFO_AW+1){1'b0}};
         end
      end else begin
         regnum_q  <= regnum_d;
         byteidx_q <= byteidx_d;
         txbyte_q  <= txbyte_d;
         txvalid_q <= txvalid_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         cmd_q     <= cmd_d;
         cmd_v_q   <= cmd_v_d;
         for (int c = 0; c < NCH; c++) begin
            cmdbyte_q[c] <= cmdbyte_d[c];
            status_q[c]  <= status_d[c];
            wr_ptr_q[c]  <= wr_ptr_d[c];
            rd_ptr_q[c]  <= rd_ptr_d[c];
         end
      end
   end

   // Scan-code storage; contents are don't-care until the pointers cover them
   always_ff @(posedge clk6x) begin
      for (int c = 0; c < NCH; c++) begin
         if (push_s[c]) begin
            mem_q[c][wr_ptr_q[c][FIFO_AW-1:0]] <= ps2_code_i[8*c +: 8];
         end
      end
   end

   assign txbyte_o    = txbyte_q;
   assign ps2_cmd_o   = cmd_q;
   assign ps2_cmd_v_o = cmd_v_q;

endmodule

// File: tb/tb_smc_ps2_hub.sv
// Self-checking bench for smc_ps2_hub: directed scenarios plus random scan-code traffic
// checked against a queue-based model of the register map.
module tb_smc_ps2_hub;
   localparam int NCH   = 2;
   localparam int DEPTH = 8;

   logic             clk6x = 1'b0;
   logic             reset;
   logic             devsel_i, rw_bit_i, rxbyte_v_i, txbyte_deq_i;
   logic [7:0]       rxbyte_i, txbyte_o;
   logic [8*NCH-1:0] ps2_code_i, ps2_cmd_o;
   logic [NCH-1:0]   ps2_code_v_i, ps2_busy_i, ps2_acked_i, ps2_errd_i, ps2_cmd_v_o;

   always #10 clk6x = ~clk6x;

   smc_ps2_hub #(.NCH(NCH), .FIFO_AW(3)) dut (
      .clk6x(clk6x), .reset(reset),
      .devsel_i(devsel_i), .rw_bit_i(rw_bit_i),
      .rxbyte_i(rxbyte_i), .rxbyte_v_i(rxbyte_v_i),
      .txbyte_o(txbyte_o), .txbyte_deq_i(txbyte_deq_i),
      .ps2_code_i(ps2_code_i), .ps2_code_v_i(ps2_code_v_i),
      .ps2_busy_i(ps2_busy_i), .ps2_acked_i(ps2_acked_i), .ps2_errd_i(ps2_errd_i),
      .ps2_cmd_o(ps2_cmd_o), .ps2_cmd_v_o(ps2_cmd_v_o)
   );

   int total = 0;
   int bad   = 0;

   // reference model
   logic [7:0]     mq [NCH][$];
   logic [NCH-1:0] movf;
   logic [7:0]     mstat [NCH];

   int         pulses [NCH];
   logic [7:0] last_cmd [NCH];

   // command strobe monitor
   always @(negedge clk6x) begin
      for (int c = 0; c < NCH; c++) begin
         if (reset !== 1'b1 && ps2_cmd_v_o[c] === 1'b1) begin
            pulses[c]   = pulses[c] + 1;
            last_cmd[c] = ps2_cmd_o[8*c +: 8];
         end
      end
   end

   task automatic tick();
      @(posedge clk6x);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete();
         mstat[c] = 8'h00;
      end
      movf = '0;
   endfunction

   function automatic void model_push(input int c, input logic [7:0] code);
      if (mq[c].size() < DEPTH) mq[c].push_back(code);
      else movf[c] = 1'b1;
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] r);
      logic [7:0] v;
      int c;
      v = 8'hFF;
      if (r == 8'h30) begin
         v    = 8'(movf);
         movf = '0;
      end else if (r == 8'h07 || r == 8'h21) begin
         c = (r == 8'h07) ? 0 : 1;
         if (mq[c].size() > 0) v = mq[c].pop_front();
         else v = 8'h00;
      end else if (r == 8'h18 || r == 8'h1A) begin
         v = mstat[(int'(r) - 32'h18) / 32'sd2];
      end
      return v;
   endfunction

   task automatic push_codes(input logic [NCH-1:0] m, input logic [8*NCH-1:0] codes);
      ps2_code_i   = codes;
      ps2_code_v_i = m;
      tick();
      ps2_code_v_i = '0;
      for (int c = 0; c < NCH; c++) if (m[c]) model_push(c, codes[8*c +: 8]);
   endtask

   task automatic wr_addr(input logic [7:0] r);
      devsel_i = 1'b1; rw_bit_i = 1'b0;
      rxbyte_i = r; rxbyte_v_i = 1'b1;
      tick();
      rxbyte_v_i = 1'b0;
      tick();
      devsel_i = 1'b0;
      tick();
   endtask

   task automatic wr_reg(input logic [7:0] r, input logic [7:0] d);
      devsel_i = 1'b1; rw_bit_i = 1'b0;
      rxbyte_i = r; rxbyte_v_i = 1'b1;
      tick();
      rxbyte_i = d;
      tick();
      rxbyte_v_i = 1'b0;
      tick();
      devsel_i = 1'b0;
      tick();
      if (r == 8'h19) mstat[0] = 8'h01;
      if (r == 8'h1B) mstat[1] = 8'h01;
   endtask

   task automatic begin_rd(input logic [7:0] r);
      wr_addr(r);
      devsel_i = 1'b1; rw_bit_i = 1'b1;
      tick();
      tick();
   endtask

   task automatic rd_step(input logic [7:0] r, input string tag);
      check(tag, txbyte_o, model_read(r));
      txbyte_deq_i = 1'b1;
      tick();
      txbyte_deq_i = 1'b0;
      tick();
   endtask

   task automatic end_rd();
      devsel_i = 1'b0; rw_bit_i = 1'b0;
      tick();
   endtask

   task automatic rd_seq(input logic [7:0] r, input int n, input string tag);
      begin_rd(r);
      for (int i = 0; i < n; i++) rd_step(r, $sformatf("%s_%02h[%0d]", tag, r, i));
      end_rd();
   endtask

   initial begin
      logic [7:0] regs [6];
      logic [7:0] code;
      int p0, p1;
      regs[0] = 8'h07; regs[1] = 8'h21; regs[2] = 8'h30;
      regs[3] = 8'h18; regs[4] = 8'h1A; regs[5] = 8'h55;
      for (int c = 0; c < NCH; c++) begin pulses[c] = 0; last_cmd[c] = 8'h00; end
      devsel_i = 1'b0; rw_bit_i = 1'b0; rxbyte_i = 8'h00; rxbyte_v_i = 1'b0;
      txbyte_deq_i = 1'b0; ps2_code_i = '0; ps2_code_v_i = '0;
      ps2_busy_i = '0; ps2_acked_i = '0; ps2_errd_i = '0;
      reset = 1'b1;
      model_reset();
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_txbyte", txbyte_o, 8'hFF);
      check("rst_cmd0", ps2_cmd_o[7:0], 8'h00);
      check("rst_cmd_v", 8'(ps2_cmd_v_o), 8'h00);
      rd_seq(8'h07, 1, "rst_buf");
      rd_seq(8'h18, 1, "rst_stat");
      rd_seq(8'h30, 1, "rst_ovf");
      rd_seq(8'h55, 1, "unmapped");
      rd_seq(8'h31, 1, "reg31");

      // ch0 1C,F0,1C then four reads
      push_codes(2'b01, 16'h001C);
      push_codes(2'b01, 16'h00F0);
      push_codes(2'b01, 16'h001C);
      rd_seq(8'h07, 4, "kbd");

      // genuine 00 code is popped, empty is not
      push_codes(2'b01, 16'h0000);
      rd_seq(8'h07, 2, "zero");
      push_codes(2'b01, 16'h00AB);
      rd_seq(8'h07, 2, "after_zero");

      // nine codes into ch1 overflow it
      for (int i = 0; i < 9; i++) push_codes(2'b10, {8'($urandom_range(1, 255)), 8'h00});
      rd_seq(8'h30, 1, "ovf1");
      rd_seq(8'h30, 1, "ovf2");
      rd_seq(8'h21, 9, "mouse");

      // command held off by busy, then issued and acked
      ps2_busy_i[0] = 1'b1;
      p0 = pulses[0];
      wr_reg(8'h19, 8'hFF);
      rd_seq(8'h18, 1, "stat_pend");
      repeat (30) tick();
      check("no_pulse_busy", 8'(pulses[0] - p0), 8'h00);
      ps2_busy_i[0] = 1'b0;
      tick();
      check("cmd_v_hi", 8'(ps2_cmd_v_o[0]), 8'h01);
      check("cmd_byte", ps2_cmd_o[7:0], 8'hFF);
      tick();
      check("cmd_v_lo", 8'(ps2_cmd_v_o[0]), 8'h00);
      check("pulse_cnt0", 8'(pulses[0] - p0), 8'h01);
      rd_seq(8'h18, 1, "stat_inflight");
      ps2_acked_i[0] = 1'b1; tick(); ps2_acked_i[0] = 1'b0;
      mstat[0] = 8'hFA;
      rd_seq(8'h18, 2, "stat_ack");

      // ch1 command with error reply
      p1 = pulses[1];
      code = 8'($urandom_range(0, 255));
      wr_reg(8'h1B, code);
      check("pulse_cnt1", 8'(pulses[1] - p1), 8'h01);
      check("cmd1_byte", last_cmd[1], code);
      ps2_errd_i[1] = 1'b1; tick(); ps2_errd_i[1] = 1'b0;
      mstat[1] = 8'hFE;
      rd_seq(8'h1A, 1, "stat_err");

      // ack and error together resolve to error
      ps2_acked_i[0] = 1'b1; ps2_errd_i[0] = 1'b1; tick();
      ps2_acked_i[0] = 1'b0; ps2_errd_i[0] = 1'b0;
      mstat[0] = 8'hFE;
      rd_seq(8'h18, 1, "stat_both");

      // unmapped write ignored
      wr_reg(8'h40, 8'h55);
      rd_seq(8'h18, 1, "after_unmapped");

      // full FIFO with push and pop in the same clock
      for (int i = 0; i < DEPTH; i++) push_codes(2'b01, {8'h00, 8'($urandom_range(0, 255))});
      begin_rd(8'h07);
      check("full_head", txbyte_o, model_read(8'h07));
      code = 8'($urandom_range(0, 255));
      ps2_code_i[7:0] = code; ps2_code_v_i[0] = 1'b1; txbyte_deq_i = 1'b1;
      model_push(0, code);
      tick();
      ps2_code_v_i[0] = 1'b0; txbyte_deq_i = 1'b0;
      tick();
      for (int i = 0; i < DEPTH + 1; i++) rd_step(8'h07, $sformatf("full_pop[%0d]", i));
      end_rd();
      rd_seq(8'h30, 1, "full_ovf");

      // random traffic
      for (int it = 0; it < 40; it++) begin
         push_codes(2'($urandom_range(0, 3)), 16'($urandom()));
         if ($urandom_range(0, 3) == 0)
            rd_seq(regs[$urandom_range(0, 5)], $urandom_range(1, 3), "rnd");
      end
      rd_seq(8'h30, 1, "drain");
      rd_seq(8'h07, DEPTH + 1, "drain");
      rd_seq(8'h21, DEPTH + 1, "drain");

      // reset mid-read with a pending command
      push_codes(2'b01, 16'h0011);
      push_codes(2'b01, 16'h0022);
      ps2_busy_i[0] = 1'b1;
      wr_reg(8'h19, 8'hAA);
      p0 = pulses[0];
      begin_rd(8'h07);
      rd_step(8'h07, "pre_rst");
      reset = 1'b1;
      tick();
      check("mid_rst_txbyte", txbyte_o, 8'hFF);
      devsel_i = 1'b0; rw_bit_i = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      ps2_busy_i[0] = 1'b0;
      repeat (5) tick();
      check("rst_txbyte2", txbyte_o, 8'hFF);
      check("rst_no_pulse", 8'(pulses[0] - p0), 8'h00);
      check("rst_cmd0b", ps2_cmd_o[7:0], 8'h00);
      rd_seq(8'h07, 1, "post_rst");
      rd_seq(8'h18, 1, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
